// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and iteration count for the multiply/divide unit
// Contents: state_t (FSM states), mul_op_t / div_op_t (2-bit op encodings),
// iter_count() returning CALC cycles for a given XLEN.
// Build option: MULDIV_RADIX4_EN halves the CALC cycle count (two steps per cycle).
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CALC  = 2'b01,
        FIXUP = 2'b10,
        DONE  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_t;

    // Bit 1 selects remainder, bit 0 selects unsigned.
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_t;

    function automatic int iter_count(input int xlen);
`ifdef MULDIV_RADIX4_EN
        return xlen / 2;
`else
        return xlen;
`endif
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - request/response bundle between execute stage and muldiv_unit
// master: drives start, is_div, mul_ctrl, div_ctrl, op_a, op_b, flush; reads busy, valid, result.
// slave:  the unit side (mirror directions).
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            is_div;
    logic [1:0]      mul_ctrl;
    logic [1:0]      div_ctrl;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            busy;
    logic            valid;
    logic [XLEN-1:0] result;

    modport master (
        output start, is_div, mul_ctrl, div_ctrl, op_a, op_b, flush,
        input  busy, valid, result
    );

    modport slave (
        input  start, is_div, mul_ctrl, div_ctrl, op_a, op_b, flush,
        output busy, valid, result
    );
endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational shift-add / restoring-subtract iteration
// Inputs:  is_div, hi (partial product high / partial remainder),
//          lo (multiplier bits / dividend-then-quotient bits), opnd (multiplicand / divisor).
// Outputs: hi_next, lo_next after one iteration.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] opnd,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);
    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;

    always_comb begin
        sum     = {1'b0, hi} + {1'b0, (lo[0] ? opnd : {XLEN{1'b0}})};
        shifted = {hi, lo[XLEN-1]};
        if (is_div) begin
            // Remainder stays below the divisor, so the subtraction result fits in XLEN bits.
            if (shifted >= {1'b0, opnd}) begin
                hi_next = XLEN'(shifted - {1'b0, opnd});
                lo_next = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_next = shifted[XLEN-1:0];
                lo_next = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            // Add-then-shift right: the carry out becomes the new top bit of hi.
            hi_next = sum[XLEN:1];
            lo_next = {sum[0], lo[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M/RV64M multiply/divide unit
// Ports: clk, rst (sync active-high), bus (muldiv_if.slave: start/is_div/mul_ctrl/div_ctrl/
//        op_a/op_b/flush in; busy/valid/result out).
// Build option: MULDIV_RADIX4_EN chains two step instances, halving CALC cycles.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic    clk,
    input  logic    rst,
    muldiv_if.slave bus
);
    localparam int N  = iter_count(XLEN);
    localparam int CW = $clog2(N);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] hi, lo, opnd, hi_n, lo_n, result_q;
    logic [1:0]      ctrl_q;
    logic            is_div_q, neg_res, neg_rem, busy_q, valid_q;

    logic [1:0]        ctrl_in;
    logic              sign_a, sign_b, a_neg, b_neg, fast;
    logic [XLEN-1:0]   mag_a, mag_b, fast_result, fixed;
    logic [2*XLEN-1:0] prod;

    // Request decode, used only on the accept edge.
    always_comb begin
        ctrl_in = bus.is_div ? bus.div_ctrl : bus.mul_ctrl;
        if (bus.is_div) begin
            sign_a = !ctrl_in[0];
            sign_b = !ctrl_in[0];
        end else begin
            sign_a = (ctrl_in != OP_MULHU);
            sign_b = (ctrl_in == OP_MUL) || (ctrl_in == OP_MULH);
        end
        a_neg = sign_a && bus.op_a[XLEN-1];
        b_neg = sign_b && bus.op_b[XLEN-1];
        mag_a = a_neg ? -bus.op_a : bus.op_a;
        mag_b = b_neg ? -bus.op_b : bus.op_b;
        fast  = bus.is_div && ((bus.op_b == '0) ||
                (sign_a && (bus.op_a == MOST_NEG) && (bus.op_b == '1)));
        if (bus.op_b == '0) fast_result = ctrl_in[1] ? bus.op_a : '1;
        else                fast_result = ctrl_in[1] ? '0 : bus.op_a;
    end

    // Sign correction applied while in FIXUP.
    always_comb begin
        prod = {hi, lo};
        if (neg_res) prod = -prod;
        if (is_div_q) fixed = ctrl_q[1] ? (neg_rem ? -hi : hi) : (neg_res ? -lo : lo);
        else          fixed = (ctrl_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

`ifdef MULDIV_RADIX4_EN
    logic [XLEN-1:0] hi_mid, lo_mid;
    muldiv_step #(.XLEN(XLEN)) u_step0 (
        .is_div(is_div_q), .hi(hi), .lo(lo), .opnd(opnd), .hi_next(hi_mid), .lo_next(lo_mid)
    );
    muldiv_step #(.XLEN(XLEN)) u_step1 (
        .is_div(is_div_q), .hi(hi_mid), .lo(lo_mid), .opnd(opnd), .hi_next(hi_n), .lo_next(lo_n)
    );
`else
    muldiv_step #(.XLEN(XLEN)) u_step0 (
        .is_div(is_div_q), .hi(hi), .lo(lo), .opnd(opnd), .hi_next(hi_n), .lo_next(lo_n)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            opnd     <= '0;
            ctrl_q   <= '0;
            is_div_q <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            valid_q <= 1'b0;
            if (bus.flush) begin
                state  <= IDLE;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    CALC: begin
                        hi <= hi_n;
                        lo <= lo_n;
                        if (cnt == '0) state <= FIXUP;
                        else           cnt   <= cnt - CW'(1);
                    end
                    FIXUP: begin
                        result_q <= fixed;
                        state    <= DONE;
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b0;
                    end
                    default: begin
                        // IDLE and DONE both accept, giving back-to-back issue.
                        if (bus.start) begin
                            is_div_q <= bus.is_div;
                            ctrl_q   <= ctrl_in;
                            neg_res  <= a_neg ^ b_neg;
                            neg_rem  <= a_neg;
                            if (fast) begin
                                result_q <= fast_result;
                                state    <= DONE;
                                valid_q  <= 1'b1;
                                busy_q   <= 1'b0;
                            end else begin
                                hi     <= '0;
                                lo     <= bus.is_div ? mag_a : mag_b;
                                opnd   <= bus.is_div ? mag_b : mag_a;
                                cnt    <= CW'(N - 1);
                                state  <= CALC;
                                busy_q <= 1'b1;
                            end
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.busy   = busy_q;
    assign bus.valid  = valid_q;
    assign bus.result = result_q;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M/RV64M multiply/divide execution unit; consumes the decoder's mul_ctrl/div_ctrl encodings plus operands from the execute stage.
- Sits beside the ALU. Stalls the pipeline via busy until valid.
- Parametrised in XLEN. Adds sequential start/busy/valid/flush behaviour and full RISC-V corner-case handling.

Parameters:
- XLEN, 32, operand/result width; must be even and ≥ 8.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  request; accepted only in IDLE
- is_div  in  1  1 = divide class (div_ctrl), 0 = multiply class (mul_ctrl)
- mul_ctrl  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- div_ctrl  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- op_a  in  XLEN  rs1 operand (dividend / multiplicand)
- op_b  in  XLEN  rs2 operand (divisor / multiplier)
- flush  in  1  kill in-flight operation (branch mispredict / trap)
- busy  out  1  high from accept edge until the cycle valid is asserted
- valid  out  1  one-cycle result strobe
- result  out  XLEN  result; held until next accepted start

Behaviour:
- Reset: state IDLE; busy = 0, valid = 0, result = 0; all internal registers cleared. Reset mid-operation aborts with no valid.
- Operands and op code are captured on the accept edge (IDLE & start & !flush). Inputs are ignored afterwards; start while busy is ignored.
- States: IDLE → CALC → FIXUP → DONE → IDLE.
  - CALC runs N = XLEN iterations (XLEN/2 with the optional feature), 1 per cycle, tracked by a counter.
  - FIXUP applies sign correction.
  - DONE asserts valid for exactly one cycle.
- Latency: valid is high N+2 cycles after the accept edge (34 for XLEN = 32).
- busy is 1 in CALC and FIXUP, 0 in DONE. Back-to-back start in DONE is accepted.
- Multiply:
  - Operands are converted to magnitudes per signedness: MUL/MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned.
  - Unsigned shift-add into a 2·XLEN accumulator.
  - FIXUP negates the product if the signs differ.
  - MUL returns the low XLEN bits; the others return the high XLEN bits.
- Divide:
  - Restoring radix-2 on magnitudes; quotient and remainder are XLEN each.
  - FIXUP: quotient negated if the signs differ (signed ops); remainder takes the dividend's sign.
- Fast path (IDLE → DONE, valid one cycle after accept):
  - Divisor = 0: DIV/DIVU return all ones; REM/REMU return op_a.
  - Signed overflow, op_a = 1 followed by XLEN−1 zeros (most-negative) with op_b = all ones: DIV returns op_a, REM returns 0.
- Flush:
  - Flush in any state forces IDLE next cycle with valid = 0; result keeps its previous value.
  - Flush together with start in IDLE: start is dropped.
  - Flush in DONE: valid is still asserted that cycle, since the result is already committed.
- Counter wrap-around: the counter is loaded to N−1 on accept and CALC exits when it reaches 0. The counter never wraps.

Optional Feature:
- Macro MULDIV_RADIX4_EN.
- Defined: two iteration steps per CALC cycle, N = XLEN/2; valid at XLEN/2+2 cycles after accept (18 for XLEN = 32). Fast path is unchanged.
- Undefined: one step per cycle, N = XLEN. Results are bit-identical in both builds.

Decomposition:
- Package muldiv_pkg:
  - typedef enum state_t {IDLE, CALC, FIXUP, DONE}
  - typedef enum mul_op_t, div_op_t matching the 2-bit encodings above
  - function returning N for a given XLEN
- Sub-module muldiv_step: purely combinational, one shift-add / one restoring-subtract iteration. Instantiated once, or chained twice under MULDIV_RADIX4_EN.

Test Plan (XLEN = 32):
- MUL 7 × 0xFFFFFFFD → result 0xFFFFFFEB, valid exactly 34 cycles after accept, busy high for cycles 1–33.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 0xFFFFFFFF / 2 → 0x7FFFFFFF; REMU 17 / 5 → 2.
- Corner cases via fast path:
  - DIV 5 / 0 → 0xFFFFFFFF and REMU 5 / 0 → 5, each with valid 1 cycle after accept.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same operands → 0.
- Control:
  - Flush at CALC cycle 10 → no valid, IDLE next cycle, result unchanged.
  - rst at cycle 5 → busy/valid/result = 0.
  - Start pulsed while busy → ignored; the original result is unaffected.
- Back-to-back: start held high through DONE → second operation accepted in the DONE cycle, both results correct. Repeat the whole suite with MULDIV_RADIX4_EN defined and check latency 18 and fast path 1.
